// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg
//   Shared definitions for the UART APB initiator and anything that talks to it:
//   - apb_state_t   : initiator FSM state encoding
//   - TIMEOUT_CYCLES_DEF : default ACCESS wait budget for the timeout build
//   - REG_*         : UART register byte offsets, for drivers and benches
package uart_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    localparam logic [31:0] REG_THR_RBR = 32'h0000_0000;
    localparam logic [31:0] REG_IER     = 32'h0000_0004;
    localparam logic [31:0] REG_FCR     = 32'h0000_0008;
    localparam logic [31:0] REG_LCR     = 32'h0000_000C;
    localparam logic [31:0] REG_LSR     = 32'h0000_0014;
    localparam logic [31:0] REG_DLL     = 32'h0000_0020;
    localparam logic [31:0] REG_DLH     = 32'h0000_0024;
    localparam logic [31:0] REG_PWREMU  = 32'h0000_0030;

endpackage

// File: rtl/uart_apb_mst_timer.sv
// uart_apb_mst_timer
//   16-bit saturating wait counter used to bound APB ACCESS phases.
//   Only instantiated when UART_APB_MASTER_TIMEOUT_EN is defined.
//   Ports:
//     pclk, presetn : clock, asynchronous active-low reset
//     i_clr         : clear the count (has priority over i_inc)
//     i_inc         : count one more waited cycle
//     o_expired     : count has reached LIMIT-1, i.e. the current waited
//                     cycle is the LIMIT-th one
module uart_apb_mst_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic [15:0] LIMIT_M1 = 16'(LIMIT - 1);

    logic [15:0] r_count;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Expiry is judged against the count before this cycle is added, so the
    // LIMIT-th low-pready cycle is the one that ends the transfer.
    assign o_expired = (r_count >= LIMIT_M1);

endmodule

// File: rtl/uart_apb_master.sv
// uart_apb_master
//   APB initiator: converts a valid/ready command stream into APB SETUP/ACCESS
//   transfers and returns read data / completion status on a valid/ready
//   response channel. One transfer outstanding at a time.
//   Optional feature macro: UART_APB_MASTER_TIMEOUT_EN (bounded ACCESS wait,
//   rsp_err reports expiry). Without it ACCESS waits forever and rsp_err = 0.
//   Ports:
//     pclk, presetn                       : clock, async active-low reset
//     cmd_valid/cmd_ready/cmd_write/
//     cmd_addr/cmd_wdata                  : command channel
//     rsp_valid/rsp_ready/rsp_rdata/rsp_err : response channel
//     psel/penable/pwrite/paddr/pwdata/
//     pready/prdata                       : APB requester port
module uart_apb_master
    import uart_apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("uart_apb_master: TIMEOUT_CYCLES must be within 2..65535");
    end

    apb_state_t        r_state;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

`ifdef UART_APB_MASTER_TIMEOUT_EN
    logic r_rsp_err;
    logic w_tmo_clr;
    logic w_tmo_inc;
    logic w_tmo_expired;

    // SETUP always precedes ACCESS, so clearing there is a clear on entry.
    assign w_tmo_clr = (r_state == SETUP);
    assign w_tmo_inc = (r_state == ACCESS) && !pready;

    uart_apb_mst_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .pclk      (pclk),
        .presetn   (presetn),
        .i_clr     (w_tmo_clr),
        .i_inc     (w_tmo_inc),
        .o_expired (w_tmo_expired)
    );

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef UART_APB_MASTER_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_pwrite <= cmd_write;
                        r_paddr  <= cmd_addr;
                        // pwdata keeps its last write value across reads
                        if (cmd_write) begin
                            r_pwdata <= cmd_wdata;
                        end
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // pready on the expiry cycle still counts as completion
                    if (pready) begin
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
`ifdef UART_APB_MASTER_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
`ifdef UART_APB_MASTER_TIMEOUT_EN
                    else if (w_tmo_expired) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule
